alu_arbiter: RTL and testbench

Shares the single combinational `ALU` between two requesters (port 0: EXU, port 1: auxiliary unit such as the CSR/address path) using valid/ready handshakes and round-robin priority. It registers the granted operands, drives the ALU for one cycle, captures result/zero/less, and holds the response to the owning requester until it is accepted. It sits between the requesters and the ALU instance in the NPC core; the ALU itself stays external.

---
 rtl/alu_arbiter_pkg.sv | 37 +++
 rtl/alu_arbiter_rr_pick2.sv | 14 +
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared encodings and bundles for the two-port ALU arbiter.
// ALU op codes are the ones the external ALU decodes; the arbiter passes them through unchecked.
package alu_arbiter_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd6;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd9;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              less;
    } alu_resp_t;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin picker: grants are one-hot or zero.
// last = 1 means port 1 was granted most recently, so port 0 wins a conflict.
module rr_pick2 (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic g0,
    output logic g1
);

    assign g0 = v0 & (~v1 | last);
    assign g1 = v1 & (~v0 | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: IDLE grants,
// EXEC drives the ALU from latched operands, RESP holds the result for the owner.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_less,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_less
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    alu_req_t   req_q, req_d;
    alu_resp_t  rsp_q, rsp_d;
    logic       g0, g1;

    rr_pick2 u_pick (
        .v0   (req0_valid),
        .v1   (req1_valid),
        .last (last_grant_q),
        .g0   (g0),
        .g1   (g1)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        rsp_d        = rsp_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                req0_ready = g0;
                req1_ready = g1;
                if (g0 | g1) begin
                    owner_d      = g1;
                    last_grant_d = g1;
                    req_d        = g1 ? '{req1_op, req1_a, req1_b}
                                      : '{req0_op, req0_a, req0_b};
                    state_d      = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rsp_d   = '{alu_result, alu_zero, alu_less};
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                // Only the owner's ready can retire the response.
                if (owner_q ? resp1_ready : resp0_ready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            req_q        <= '{ALU_ADD, '0, '0};
            rsp_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            rsp_q        <= rsp_d;
        end
    end

    assign resp0_valid = (state_q == ARB_RESP) && !owner_q;
    assign resp1_valid = (state_q == ARB_RESP) &&  owner_q;
    assign resp_result = rsp_q.result;
    assign resp_zero   = rsp_q.zero;
    assign resp_less   = rsp_q.less;
    assign alu_op      = req_q.op;
    assign alu_a       = req_q.a;
    assign alu_b       = req_q.b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a transaction-level model and a stub ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        resp0_valid, resp1_valid, resp0_ready = 0, resp1_ready = 0;
    logic [31:0] resp_result;
    logic        resp_zero, resp_less;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero, alu_less;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_less(resp_less),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less)
    );

    // Behaviour of the external ALU: {result, zero, less}.
    function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        l;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            default:  r = 32'h0;
        endcase
        l = (op == ALU_SLT) ? ($signed(a) < $signed(b)) : (a < b);
        return {r, r == 32'h0, l};
    endfunction

    always_comb {alu_result, alu_zero, alu_less} = alu_ref(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a transaction is either absent, waiting one cycle on the ALU, or
    // presenting its response until the owner takes it.
    bit          m_busy, m_owner, m_last, m_resp_phase;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    logic        m_z, m_l;

    logic        obs_rdy0, obs_rdy1, obs_v0, obs_v1, obs_zero, obs_less;
    logic [31:0] obs_res;
    logic [3:0]  obs_op;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_resp_phase = 0;
        m_op = ALU_ADD; m_a = 0; m_b = 0; m_res = 0; m_z = 0; m_l = 0;
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks it.
    task automatic step(input logic v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic r0, input logic r1);
        int g;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        resp0_ready = r0; resp1_ready = r1;
        @(negedge clk);
        obs_rdy0 = req0_ready; obs_rdy1 = req1_ready; obs_v0 = resp0_valid; obs_v1 = resp1_valid;
        obs_res = resp_result; obs_zero = resp_zero; obs_less = resp_less; obs_op = alu_op;
        g = -1;
        if (!m_busy) begin
            if (v0 && v1) g = m_last ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("resp0_valid", 32'(resp0_valid), 32'(m_busy && m_resp_phase && !m_owner));
        chk("resp1_valid", 32'(resp1_valid), 32'(m_busy && m_resp_phase && m_owner));
        chk("resp_result", resp_result, m_res);
        chk("resp_flags", 32'({resp_zero, resp_less}), 32'({m_z, m_l}));
        chk("alu_op", 32'(alu_op), 32'(m_op));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        if (g >= 0) begin
            m_busy = 1; m_resp_phase = 0; m_owner = (g == 1); m_last = (g == 1);
            m_op = (g == 1) ? o1 : o0;
            m_a  = (g == 1) ? a1 : a0;
            m_b  = (g == 1) ? b1 : b0;
        end else if (m_busy && !m_resp_phase) begin
            {m_res, m_z, m_l} = alu_ref(m_op, m_a, m_b);
            m_resp_phase = 1;
        end else if (m_busy && (m_owner ? r1 : r0)) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic r0, input logic r1);
        step(0, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 0, r0, r1);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear.
    task automatic apply_reset();
        req0_valid = 0; req1_valid = 0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
        chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_flags", 32'({resp_zero, resp_less}), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("rst_alu_ab", alu_a | alu_b, 32'd0);
        @(negedge clk);
        chk("rst_hold_resp_valid", 32'({resp0_valid, resp1_valid}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int grants[$];

    initial begin
        model_reset();
        #2;
        apply_reset();

        // Single ADD on port 0.
        step(1, ALU_ADD, 5, 7, 0, ALU_ADD, 0, 0, 1, 1);
        chk("s1_req0_ready", 32'(obs_rdy0), 32'd1);
        idle_step(1, 1);
        chk("s1_alu_op", 32'(obs_op), 32'(ALU_ADD));
        idle_step(1, 1);
        chk("s1_resp0_valid", 32'(obs_v0), 32'd1);
        chk("s1_result", obs_res, 32'd12);
        chk("s1_zero", 32'(obs_zero), 32'd0);
        chk("s1_resp1_valid", 32'(obs_v1), 32'd0);

        // Both ports saturate: grants must alternate starting at port 0.
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, ALU_SUB, 3, 3, 1, ALU_XOR, 32'hF0, 32'h0F, 1, 1);
            if (obs_rdy0 | obs_rdy1) grants.push_back(int'(obs_rdy1));
            if (obs_v0) begin
                chk("s2_p0_result", obs_res, 32'd0);
                chk("s2_p0_zero", 32'(obs_zero), 32'd1);
            end
            if (obs_v1) chk("s2_p1_result", obs_res, 32'hFF);
        end
        chk("s2_grant_count", 32'(grants.size()), 32'd4);
        foreach (grants[k]) chk("s2_grant_order", 32'(grants[k]), 32'(k % 2));

        // SLTU on port 1 with a stalled response.
        step(0, ALU_ADD, 0, 0, 1, ALU_SLTU, 1, 32'hFFFF_FFFF, 1, 1);
        idle_step(1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, ALU_ADD, 0, 0, 1, ALU_ADD, 0, 0, 1, 0);
            chk("s3_resp1_valid", 32'(obs_v1), 32'd1);
            chk("s3_result", obs_res, 32'd1);
            chk("s3_less", 32'(obs_less), 32'd1);
            chk("s3_no_ready", 32'({obs_rdy0, obs_rdy1}), 32'd0);
        end
        idle_step(0, 1);
        step(1, ALU_OR, 32'h10, 32'h01, 0, ALU_ADD, 0, 0, 1, 1);
        chk("s3_back_to_idle", 32'(obs_rdy0), 32'd1);

        // Port 0 response pending; only port 1's ready is raised.
        idle_step(1, 1);
        idle_step(0, 1);
        idle_step(0, 1);
        chk("s4_still_pending", 32'(obs_v0), 32'd1);
        idle_step(1, 0);

        // Reset while in EXEC, then while in RESP.
        step(1, ALU_ADD, 9, 9, 0, ALU_ADD, 0, 0, 1, 1);
        apply_reset();
        step(1, ALU_ADD, 1, 1, 1, ALU_ADD, 2, 2, 1, 1);
        chk("s5_exec_rst_grant0", 32'({obs_rdy1, obs_rdy0}), 32'b01);
        idle_step(0, 0);
        apply_reset();
        step(1, ALU_ADD, 1, 1, 1, ALU_ADD, 2, 2, 1, 1);
        chk("s5_resp_rst_grant0", 32'({obs_rdy1, obs_rdy0}), 32'b01);
        idle_step(1, 1);
        idle_step(1, 1);

        // Port 0 pulses valid while busy with port 1, then drops it.
        step(0, ALU_ADD, 0, 0, 1, ALU_AND, 32'hFF, 32'h0F, 1, 1);
        step(1, ALU_ADD, 4, 4, 0, ALU_ADD, 0, 0, 1, 1);
        idle_step(1, 1);
        chk("s6_resp1_only", 32'({obs_v0, obs_v1}), 32'b01);
        idle_step(1, 1);
        chk("s6_no_resp0", 32'(obs_v0), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), $urandom, $urandom,
                 $urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            if (i == 200) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
